uart_axi_buffer: RTL and testbench

AXI4-Lite slave that the mem stage's UART bus talks to. It buffers bytes between the CPU and a serial PHY: received bytes (uart_rx strobes) go into an RX FIFO, and CPU stores go into a TX FIFO that drains to the transmitter. It also provides status and control registers. Reads and writes of data stall on the bus when the FIFOs are not ready, so a CPU lbu/sb is blocking.

---
 rtl/uart_axi_pkg.sv | 30 +++
 rtl/uart_axi_buffer_if.sv | 40 ++++
 rtl/uart_axi_buffer_byte_fifo.sv | 52 +++++
 rtl/uart_axi_buffer.sv | 252 +++++++++++++++++++++++++
 tb/tb_uart_axi_buffer.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_axi_pkg.sv
// Register map, status bit positions and FSM state types
// shared by the UART AXI4-Lite buffer.
package uart_axi_pkg;

   localparam logic [1:0] REG_RX_DATA = 2'd0;
   localparam logic [1:0] REG_TX_DATA = 2'd1;
   localparam logic [1:0] REG_STAT    = 2'd2;
   localparam logic [1:0] REG_CTRL    = 2'd3;

   localparam int STAT_RX_NEMPTY = 0;
   localparam int STAT_RX_FULL   = 1;
   localparam int STAT_TX_EMPTY  = 2;
   localparam int STAT_TX_FULL   = 3;
   localparam int STAT_OVERRUN   = 4;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef enum logic [1:0] {
      R_IDLE,
      R_WAIT,
      R_RESP
   } r_state_t;

   typedef enum logic [1:0] {
      W_COLLECT,
      W_EXEC,
      W_RESP
   } w_state_t;

endpackage

// File: rtl/uart_axi_buffer_if.sv
// AXI4-Lite bus bundle between the mem stage and the UART buffer.
interface uart_axi_buffer_if;

   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [2:0]  arprot;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [2:0]  awprot;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      output araddr, arvalid, arprot, rready,
      output awaddr, awvalid, awprot,
      output wdata, wstrb, wvalid, bready,
      input  arready, rdata, rresp, rvalid,
      input  awready, wready, bresp, bvalid
   );

   modport slave (
      input  araddr, arvalid, arprot, rready,
      input  awaddr, awvalid, awprot,
      input  wdata, wstrb, wvalid, bready,
      output arready, rdata, rresp, rvalid,
      output awready, wready, bresp, bvalid
   );

endinterface

// File: rtl/uart_axi_buffer_byte_fifo.sv
// Byte FIFO with wrap-bit pointers; push on full succeeds
// only when a pop happens in the same cycle.
module byte_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       push,
   input  logic       pop,
   input  logic       flush,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       empty,
   output logic       full
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [7:0]          mem [DEPTH];
   logic [DEPTH_LOG2:0] wptr;
   logic [DEPTH_LOG2:0] rptr;
   logic                do_push;
   logic                do_pop;

   assign empty = (wptr == rptr);
   assign full  = (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]) &&
                  (wptr[DEPTH_LOG2-1:0] == rptr[DEPTH_LOG2-1:0]);

   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rptr[DEPTH_LOG2-1:0]];

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wptr <= '0;
         rptr <= '0;
      end else if (flush) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end

   // Storage needs no reset: pointers define validity.
   always_ff @(posedge clk) begin
      if (do_push && !flush)
         mem[wptr[DEPTH_LOG2-1:0]] <= din;
   end

endmodule

// File: rtl/uart_axi_buffer.sv
// AXI4-Lite slave buffering UART RX/TX bytes with status and
// control registers; data accesses stall while FIFOs are not ready.
module uart_axi_buffer
   import uart_axi_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4,
   parameter bit BLOCKING   = 1'b1
) (
   input  logic               clk,
   input  logic               rstn,
   uart_axi_buffer_if.slave   s,
   input  logic [7:0]         rx_data,
   input  logic               rx_strobe,
   output logic [7:0]         tx_data,
   output logic               tx_valid,
   input  logic               tx_ready
);

   r_state_t    r_state, r_next;
   logic [1:0]  raddr, raddr_n;
   logic        arready_q, arready_n;
   logic        rvalid_q, rvalid_n;
   logic [31:0] rdata_q, rdata_n;
   logic        rx_pop;
   logic        stat_rd;

   w_state_t    w_state, w_next;
   logic [1:0]  waddr, waddr_n;
   logic [7:0]  wbyte, wbyte_n;
   logic        wen, wen_n;
   logic        aw_got, aw_got_n;
   logic        w_got, w_got_n;
   logic        awready_q, awready_n;
   logic        wready_q, wready_n;
   logic        bvalid_q, bvalid_n;
   logic        flush_tx_q, flush_tx_n;
   logic        flush_rx_q, flush_rx_n;
   logic        tx_push;

   logic [7:0]  rx_dout;
   logic        rx_empty, rx_full;
   logic        tx_empty, tx_full;
   logic        tx_pop;
   logic        overrun;
   logic        ovr_set;
   logic [4:0]  stat;
   logic        unused_ok;

   byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx (
      .clk   (clk),
      .rstn  (rstn),
      .push  (rx_strobe),
      .pop   (rx_pop),
      .flush (flush_rx_q),
      .din   (rx_data),
      .dout  (rx_dout),
      .empty (rx_empty),
      .full  (rx_full)
   );

   byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx (
      .clk   (clk),
      .rstn  (rstn),
      .push  (tx_push),
      .pop   (tx_pop),
      .flush (flush_tx_q),
      .din   (wbyte),
      .dout  (tx_data),
      .empty (tx_empty),
      .full  (tx_full)
   );

   assign tx_valid = ~tx_empty;
   assign tx_pop   = tx_valid & tx_ready;

   always_comb begin
      stat                 = '0;
      stat[STAT_RX_NEMPTY] = ~rx_empty;
      stat[STAT_RX_FULL]   = rx_full;
      stat[STAT_TX_EMPTY]  = tx_empty;
      stat[STAT_TX_FULL]   = tx_full;
      stat[STAT_OVERRUN]   = overrun;
   end

   always_comb begin
      r_next    = r_state;
      raddr_n   = raddr;
      arready_n = arready_q;
      rvalid_n  = rvalid_q;
      rdata_n   = rdata_q;
      rx_pop    = 1'b0;
      stat_rd   = 1'b0;
      unique case (r_state)
         R_IDLE: begin
            if (s.arvalid && arready_q) begin
               raddr_n   = s.araddr[3:2];
               arready_n = 1'b0;
               r_next    = R_WAIT;
            end
         end
         R_WAIT: begin
            if (!(raddr == REG_RX_DATA && rx_empty && BLOCKING)) begin
               rvalid_n = 1'b1;
               rdata_n  = '0;
               r_next   = R_RESP;
               case (raddr)
                  REG_RX_DATA: begin
                     rx_pop = ~rx_empty;
                     if (!rx_empty) rdata_n = {24'b0, rx_dout};
                  end
                  REG_STAT: begin
                     rdata_n = {27'b0, stat};
                     stat_rd = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         R_RESP: begin
            if (s.rready) begin
               rvalid_n  = 1'b0;
               arready_n = 1'b1;
               r_next    = R_IDLE;
            end
         end
         default: r_next = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state   <= R_IDLE;
         raddr     <= '0;
         arready_q <= 1'b1;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         r_state   <= r_next;
         raddr     <= raddr_n;
         arready_q <= arready_n;
         rvalid_q  <= rvalid_n;
         rdata_q   <= rdata_n;
      end
   end

   always_comb begin
      w_next     = w_state;
      waddr_n    = waddr;
      wbyte_n    = wbyte;
      wen_n      = wen;
      aw_got_n   = aw_got;
      w_got_n    = w_got;
      awready_n  = awready_q;
      wready_n   = wready_q;
      bvalid_n   = bvalid_q;
      flush_tx_n = 1'b0;
      flush_rx_n = 1'b0;
      tx_push    = 1'b0;
      unique case (w_state)
         W_COLLECT: begin
            if (s.awvalid && awready_q) begin
               waddr_n   = s.awaddr[3:2];
               aw_got_n  = 1'b1;
               awready_n = 1'b0;
            end
            if (s.wvalid && wready_q) begin
               wbyte_n  = s.wdata[7:0];
               wen_n    = s.wstrb[0];
               w_got_n  = 1'b1;
               wready_n = 1'b0;
            end
            if (aw_got_n && w_got_n) w_next = W_EXEC;
         end
         W_EXEC: begin
            if (!(waddr == REG_TX_DATA && tx_full && BLOCKING)) begin
               bvalid_n = 1'b1;
               w_next   = W_RESP;
               case (waddr)
                  REG_TX_DATA: tx_push = wen;
                  REG_CTRL: begin
                     flush_tx_n = wen & wbyte[0];
                     flush_rx_n = wen & wbyte[1];
                  end
                  default: ;
               endcase
            end
         end
         W_RESP: begin
            if (s.bready) begin
               bvalid_n  = 1'b0;
               awready_n = 1'b1;
               wready_n  = 1'b1;
               aw_got_n  = 1'b0;
               w_got_n   = 1'b0;
               w_next    = W_COLLECT;
            end
         end
         default: w_next = W_COLLECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         w_state    <= W_COLLECT;
         waddr      <= '0;
         wbyte      <= '0;
         wen        <= 1'b0;
         aw_got     <= 1'b0;
         w_got      <= 1'b0;
         awready_q  <= 1'b1;
         wready_q   <= 1'b1;
         bvalid_q   <= 1'b0;
         flush_tx_q <= 1'b0;
         flush_rx_q <= 1'b0;
      end else begin
         w_state    <= w_next;
         waddr      <= waddr_n;
         wbyte      <= wbyte_n;
         wen        <= wen_n;
         aw_got     <= aw_got_n;
         w_got      <= w_got_n;
         awready_q  <= awready_n;
         wready_q   <= wready_n;
         bvalid_q   <= bvalid_n;
         flush_tx_q <= flush_tx_n;
         flush_rx_q <= flush_rx_n;
      end
   end

   // A byte lost to a flush is not an overrun; set beats clear.
   assign ovr_set = rx_strobe & rx_full & ~rx_pop & ~flush_rx_q;

   always_ff @(posedge clk) begin
      if (!rstn)        overrun <= 1'b0;
      else if (ovr_set) overrun <= 1'b1;
      else if (stat_rd) overrun <= 1'b0;
   end

   assign s.arready = arready_q;
   assign s.rvalid  = rvalid_q;
   assign s.rdata   = rdata_q;
   assign s.rresp   = RESP_OKAY;
   assign s.awready = awready_q;
   assign s.wready  = wready_q;
   assign s.bvalid  = bvalid_q;
   assign s.bresp   = RESP_OKAY;

   assign unused_ok = ^{s.araddr[31:4], s.araddr[1:0], s.arprot,
                        s.awaddr[31:4], s.awaddr[1:0], s.awprot,
                        s.wdata[31:8], s.wstrb[3:1]};

endmodule

// File: tb/tb_uart_axi_buffer.sv
// Self-checking bench: register vectors, directed corner cases
// and a randomized run against a queue-based model.
module tb_uart_axi_buffer;

   logic       clk;
   logic       rstn;
   logic [7:0] rx_data;
   logic       rx_strobe;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   int checks = 0;
   int errors = 0;

   uart_axi_buffer_if s ();

   uart_axi_buffer #(.DEPTH_LOG2(4), .BLOCKING(1'b1)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .s         (s),
      .rx_data   (rx_data),
      .rx_strobe (rx_strobe),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                           output int lat);
      int n;
      n = 0;
      s.araddr  = a;
      s.arvalid = 1'b1;
      while (!s.arready && n < 200) begin
         step();
         n++;
      end
      step();
      s.arvalid = 1'b0;
      lat = 0;
      while (!s.rvalid && lat < 200) begin
         step();
         lat++;
      end
      if (!s.rvalid) begin
         checks++;
         errors++;
         $display("FAIL read_timeout: addr %h got no rvalid required rvalid", a);
      end
      d = s.rdata;
      s.rready = 1'b1;
      step();
      s.rready = 1'b0;
   endtask

   task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] strb, input bit lead,
                            output logic [1:0] resp, output logic early_b,
                            output int lat);
      int  n;
      bit  aw_hs, w_hs;
      n = 0;
      early_b   = 1'b0;
      s.awaddr  = a;
      s.wdata   = d;
      s.wstrb   = strb;
      s.awvalid = 1'b1;
      s.wvalid  = !lead;
      while ((s.awvalid || s.wvalid) && n < 200) begin
         aw_hs = s.awvalid & s.awready;
         w_hs  = s.wvalid & s.wready;
         step();
         n++;
         if (aw_hs) s.awvalid = 1'b0;
         if (w_hs)  s.wvalid  = 1'b0;
         if (n == 1) begin
            early_b = s.bvalid;
            if (lead) s.wvalid = 1'b1;
         end
      end
      s.awvalid = 1'b0;
      s.wvalid  = 1'b0;
      lat = 0;
      while (!s.bvalid && lat < 200) begin
         step();
         lat++;
      end
      if (!s.bvalid) begin
         checks++;
         errors++;
         $display("FAIL write_timeout: addr %h got no bvalid required bvalid", a);
      end
      resp = s.bresp;
      s.bready = 1'b1;
      step();
      s.bready = 1'b0;
   endtask

   task automatic rx_byte(input logic [7:0] b);
      rx_data   = b;
      rx_strobe = 1'b1;
      step();
      rx_strobe = 1'b0;
   endtask

   task automatic tx_take(output logic [7:0] b, output logic v);
      v = tx_valid;
      b = tx_data;
      tx_ready = 1'b1;
      step();
      tx_ready = 1'b0;
   endtask

   logic [31:0] d;
   logic [1:0]  resp;
   logic        eb;
   logic [7:0]  b;
   logic        v;
   int          lat;
   logic [7:0]  rxq[$];
   logic [7:0]  txq[$];
   bit          ovr;

   initial begin
      tbl[0] = '{1'b1, 32'h0000_0004, 32'h0000_00A5, 4'h1, 32'h0};
      tbl[1] = '{1'b1, 32'hABC0_0004, 32'h0000_0011, 4'h0, 32'h0};
      tbl[2] = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 32'h0};
      tbl[3] = '{1'b0, 32'h1234_000C, 32'h0,         4'h0, 32'h0};
      tbl[4] = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 32'h00};
      tbl[5] = '{1'b1, 32'h0000_0008, 32'hFFFF_FFFF, 4'hF, 32'h0};
      tbl[6] = '{1'b1, 32'h0000_0000, 32'h0000_0077, 4'hF, 32'h0};
      tbl[7] = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 32'h00};
      tbl[8] = '{1'b1, 32'h0000_000C, 32'h0000_0001, 4'h1, 32'h0};
      tbl[9] = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 32'h04};

      rstn = 1'b0;
      rx_data = '0;
      rx_strobe = 1'b0;
      tx_ready = 1'b0;
      s.araddr = '0;
      s.arvalid = 1'b0;
      s.arprot = '0;
      s.rready = 1'b0;
      s.awaddr = '0;
      s.awvalid = 1'b0;
      s.awprot = '0;
      s.wdata = '0;
      s.wstrb = '0;
      s.wvalid = 1'b0;
      s.bready = 1'b0;
      repeat (3) step();
      rstn = 1'b1;
      step();

      chk("rst_arready", {31'b0, s.arready}, 1);
      chk("rst_awready", {31'b0, s.awready}, 1);
      chk("rst_wready", {31'b0, s.wready}, 1);
      chk("rst_rvalid", {31'b0, s.rvalid}, 0);
      chk("rst_bvalid", {31'b0, s.bvalid}, 0);
      chk("rst_rdata", s.rdata, 0);
      chk("rst_tx_valid", {31'b0, tx_valid}, 0);

      for (int i = 0; i < 10; i++) begin
         if (tbl[i].wr) begin
            axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, 1'b0,
                      resp, eb, lat);
            chk($sformatf("vec%0d_bresp", i), {30'b0, resp}, tbl[i].exp);
         end else begin
            axi_read(tbl[i].addr, d, lat);
            chk($sformatf("vec%0d_rdata", i), d, tbl[i].exp);
         end
      end

      rx_byte(8'h41);
      axi_read(32'h7F00_0000, d, lat);
      chk("rx41_rdata", d, 32'h41);
      chk("rx41_latency", lat, 1);
      axi_read(32'h8, d, lat);
      chk("rx41_stat", d, 32'h04);

      s.araddr  = 32'h0;
      s.arvalid = 1'b1;
      step();
      s.arvalid = 1'b0;
      repeat (10) step();
      chk("blkrd_rvalid_held", {31'b0, s.rvalid}, 0);
      rx_byte(8'h5A);
      chk("blkrd_rvalid_strobe_cycle", {31'b0, s.rvalid}, 0);
      step();
      chk("blkrd_rvalid_after", {31'b0, s.rvalid}, 1);
      chk("blkrd_rdata", s.rdata, 32'h5A);
      s.rready = 1'b1;
      step();
      s.rready = 1'b0;

      axi_write(32'h4, 32'h33, 4'h1, 1'b1, resp, eb, lat);
      chk("aw_lead_early_bvalid", {31'b0, eb}, 0);
      chk("aw_lead_bresp", {30'b0, resp}, 0);
      chk("aw_lead_tx_valid", {31'b0, tx_valid}, 1);
      chk("aw_lead_tx_data", {24'b0, tx_data}, 32'h33);
      tx_take(b, v);
      chk("aw_lead_tx_empty", {31'b0, tx_valid}, 0);

      for (int i = 0; i < 16; i++)
         axi_write(32'h4, 32'h80 + i, 4'h1, 1'b0, resp, eb, lat);
      fork
         axi_write(32'h4, 32'hEE, 4'h1, 1'b0, resp, eb, lat);
         begin
            repeat (10) @(posedge clk);
            #1;
            chk("txfull_bvalid_held", {31'b0, s.bvalid}, 0);
            tx_take(b, v);
            chk("txfull_first_pop", {24'b0, b}, 32'h80);
         end
      join
      for (int i = 1; i <= 16; i++) begin
         tx_take(b, v);
         chk($sformatf("txfull_order%0d", i), {23'b0, v, b},
             {23'b0, 1'b1, (i == 16) ? 8'hEE : 8'(8'h80 + i)});
      end
      chk("txfull_drained", {31'b0, tx_valid}, 0);

      for (int i = 1; i <= 17; i++) rx_byte(8'(i));
      axi_read(32'h8, d, lat);
      chk("ovr_stat1", d, 32'h17);
      axi_read(32'h8, d, lat);
      chk("ovr_stat2", d, 32'h07);
      for (int i = 1; i <= 16; i++) begin
         axi_read(32'h0, d, lat);
         chk($sformatf("ovr_pop%0d", i), d, i);
      end
      axi_read(32'h8, d, lat);
      chk("ovr_stat_after", d, 32'h04);

      for (int i = 0; i < 3; i++) rx_byte(8'hC0 + 8'(i));
      s.araddr  = 32'h8;
      s.arvalid = 1'b1;
      step();
      s.arvalid = 1'b0;
      step();
      chk("rst_mid_pending", {31'b0, s.rvalid}, 1);
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      chk("rst_mid_rvalid", {31'b0, s.rvalid}, 0);
      chk("rst_mid_arready", {31'b0, s.arready}, 1);
      axi_read(32'h8, d, lat);
      chk("rst_mid_stat", d, 32'h04);

      ovr = 1'b0;
      for (int k = 0; k < 300; k++) begin
         int          op;
         logic [7:0]  rb;
         logic [3:0]  st;
         logic [31:0] es;
         op = $urandom_range(0, 6);
         rb = 8'($urandom);
         if (op <= 1) begin
            rx_byte(rb);
            if (rxq.size() < 16) rxq.push_back(rb);
            else ovr = 1'b1;
         end else if (op == 2 && txq.size() < 16) begin
            st = 4'($urandom_range(0, 15));
            axi_write(32'h4, {24'($urandom), rb}, st, bit'($urandom_range(0, 1)),
                      resp, eb, lat);
            if (st[0]) txq.push_back(rb);
         end else if (op == 3 && rxq.size() > 0) begin
            axi_read(32'h0, d, lat);
            chk($sformatf("rnd%0d_rx", k), d, {24'b0, rxq.pop_front()});
         end else if (op == 4) begin
            tx_take(b, v);
            if (txq.size() > 0)
               chk($sformatf("rnd%0d_tx", k), {23'b0, v, b},
                   {23'b0, 1'b1, txq.pop_front()});
            else
               chk($sformatf("rnd%0d_txv", k), {31'b0, v}, 0);
         end else if (op == 5 && $urandom_range(0, 3) == 0) begin
            st = 4'($urandom_range(0, 3));
            axi_write(32'hC, {28'b0, st}, 4'h1, 1'b0, resp, eb, lat);
            if (st[0]) txq.delete();
            if (st[1]) rxq.delete();
         end else begin
            axi_read(32'h8, d, lat);
            es = {27'b0, ovr, txq.size() == 16, txq.size() == 0,
                  rxq.size() == 16, rxq.size() != 0};
            chk($sformatf("rnd%0d_stat", k), d, es);
            ovr = 1'b0;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
